// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin arbitration, two-slave
// address decode, SETUP/ACCESS sequencing and a hung-slave timeout.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_BIT        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]              req_write,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [1:0]              PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [2:0]              PPROT,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]      TO_VAL  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] HI_MASK = {ADDR_WIDTH{1'b1}} << (SEL_BIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DERR
  } state_t;

  state_t                  state_q, state_d;
  // Last granted requester; doubles as the round-robin pointer, so the
  // reset value of 1 makes requester 0 the favoured one.
  logic                    gnt_q, gnt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_inc;

  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [1:0]              psel_d;
  logic                    penable_d;
  logic                    pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_d;
  logic [1:0]              rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;
  logic                    rsp_slverr_d;

  logic                    win_valid;
  logic                    win_idx;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic                    win_write;
  logic [DATA_WIDTH-1:0]   win_wdata;

  assign PPROT   = 3'b000;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    win_valid = |req_valid;
    unique case (req_valid)
      2'b10:   win_idx = 1'b1;
      2'b11:   win_idx = ~gnt_q;
      default: win_idx = 1'b0;
    endcase
  end

  assign win_addr  = win_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
  assign win_wdata = win_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign win_write = req_write[win_idx];

  assign req_ready = (state_q == S_IDLE && win_valid) ? (2'b01 << win_idx) : 2'b00;

  always_comb begin
    // NOTE: every *_d defaults to its current value first, so no path through
    // the case statement leaves a variable unassigned and no latch is inferred.
    state_d      = state_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    paddr_d      = PADDR;
    psel_d       = PSEL;
    penable_d    = PENABLE;
    pwrite_d     = PWRITE;
    pwdata_d     = PWDATA;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata;
    rsp_slverr_d = rsp_slverr;

    unique case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          gnt_d     = win_idx;
          cnt_d     = '0;
          paddr_d   = win_addr;
          pwrite_d  = win_write;
          pwdata_d  = win_wdata;
          penable_d = 1'b0;
          if ((win_addr & HI_MASK) != '0) begin
            state_d = S_DERR;
          end else begin
            psel_d  = win_addr[SEL_BIT] ? 2'b10 : 2'b01;
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        if (PREADY) begin
          psel_d       = 2'b00;
          penable_d    = 1'b0;
          cnt_d        = '0;
          rsp_valid_d  = 2'b01 << gnt_q;
          rsp_slverr_d = PSLVERR;
          rsp_rdata_d  = (PWRITE || PSLVERR) ? '0 : PRDATA;
          state_d      = S_IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_inc == TO_VAL) begin
          // The slave has stalled for the full budget: abandon the transfer.
          psel_d       = 2'b00;
          penable_d    = 1'b0;
          cnt_d        = '0;
          rsp_valid_d  = 2'b01 << gnt_q;
          rsp_slverr_d = 1'b1;
          rsp_rdata_d  = '0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DERR: begin
        rsp_valid_d  = 2'b01 << gnt_q;
        rsp_slverr_d = 1'b1;
        rsp_rdata_d  = '0;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    // NOTE: non-blocking assignments so every register samples the values
    // computed before this edge, independent of statement order.
    if (PRESET) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b1;
      cnt_q      <= '0;
      PADDR      <= '0;
      PSEL       <= 2'b00;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      PADDR      <= paddr_d;
      PSEL       <= psel_d;
      PENABLE    <= penable_d;
      PWRITE     <= pwrite_d;
      PWDATA     <= pwdata_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_slverr <= rsp_slverr_d;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: a per-cycle vector table for the
// basic and alternating transfers, then hand-written corner-case sequences.
module tb_apb_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [31:0] A0 = 32'h0000_0004;
  localparam logic [31:0] A1 = 32'h0000_1008;
  localparam logic [31:0] W0 = 32'hDEAD_BEEF;
  localparam logic [31:0] W1 = 32'h0BAD_F00D;
  localparam logic [31:0] R  = 32'h1234_5678;
  localparam logic [31:0] D  = 32'hA5A5_0001;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*AW-1:0] req_addr;
  logic [1:0]      req_write;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_slverr;
  logic [AW-1:0]   PADDR;
  logic [1:0]      PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [DW-1:0]   PWDATA;
  logic [2:0]      PPROT;
  logic            PREADY;
  logic [DW-1:0]   PRDATA;
  logic            PSLVERR;

  apb_master_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_BIT(12), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PPROT(PPROT),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Bus-protocol invariants, sampled on the falling edge.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      check("psel_both_set", PSEL == 2'b11, 1'b0);
      check("penable_without_psel", PENABLE && (PSEL == 2'b00), 1'b0);
    end
  end

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  wr;
    logic        pready;
    logic [31:0] prdata;
    logic [1:0]  e_ready;
    logic [1:0]  e_psel;
    logic        e_pen;
    logic        e_pwrite;
    logic [31:0] e_paddr;
    logic [31:0] e_pwdata;
    logic [1:0]  e_rsp;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[21];

  // One full transfer with PREADY high in the first ACCESS cycle.
  task automatic xfer(input int who, input logic [31:0] addr, input logic wr,
                      input logic [31:0] prdata, input logic perr,
                      input logic [1:0] e_psel, input logic [31:0] e_rdata,
                      input logic e_err, input string tag);
    req_addr[who*AW +: AW] = addr;
    req_write[who]         = wr;
    req_valid              = 2'b01 << who;
    PREADY                 = 1'b1;
    PRDATA                 = prdata;
    PSLVERR                = perr;
    #1 check({tag, "_ready"}, req_ready, 2'b01 << who);
    tick();
    req_valid = 2'b00;
    check({tag, "_setup_psel"}, PSEL, e_psel);
    check({tag, "_setup_pen"}, PENABLE, 1'b0);
    check({tag, "_pwrite"}, PWRITE, wr);
    tick();
    check({tag, "_access_pen"}, PENABLE, 1'b1);
    tick();
    check({tag, "_rsp_valid"}, rsp_valid, 2'b01 << who);
    check({tag, "_rsp_err"}, rsp_slverr, e_err);
    check({tag, "_rsp_rdata"}, rsp_rdata, e_rdata);
    check({tag, "_psel_clr"}, PSEL, 2'b00);
    PSLVERR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          valid  wr     rdy  prdata  e_ready e_psel pen  pwr   paddr pwdata rsp    err   rdata
    vecs[0]  = '{2'b01, 2'b01, 1'b1, 32'h0, 2'b01, 2'b01, 1'b0, 1'b1, A0, W0, 2'b00, 1'b0, 32'h0};
    vecs[1]  = '{2'b00, 2'b01, 1'b1, 32'h0, 2'b00, 2'b01, 1'b1, 1'b1, A0, W0, 2'b00, 1'b0, 32'h0};
    vecs[2]  = '{2'b00, 2'b01, 1'b1, 32'h0, 2'b00, 2'b00, 1'b0, 1'b1, A0, W0, 2'b01, 1'b0, 32'h0};
    vecs[3]  = '{2'b10, 2'b00, 1'b0, 32'h0, 2'b10, 2'b10, 1'b0, 1'b0, A1, W1, 2'b00, 1'b0, 32'h0};
    vecs[4]  = '{2'b00, 2'b00, 1'b0, 32'h0, 2'b00, 2'b10, 1'b1, 1'b0, A1, W1, 2'b00, 1'b0, 32'h0};
    vecs[5]  = '{2'b00, 2'b00, 1'b0, 32'h0, 2'b00, 2'b10, 1'b1, 1'b0, A1, W1, 2'b00, 1'b0, 32'h0};
    vecs[6]  = '{2'b00, 2'b00, 1'b0, 32'h0, 2'b00, 2'b10, 1'b1, 1'b0, A1, W1, 2'b00, 1'b0, 32'h0};
    vecs[7]  = '{2'b00, 2'b00, 1'b0, 32'h0, 2'b00, 2'b10, 1'b1, 1'b0, A1, W1, 2'b00, 1'b0, 32'h0};
    vecs[8]  = '{2'b00, 2'b00, 1'b1, R,     2'b00, 2'b00, 1'b0, 1'b0, A1, W1, 2'b10, 1'b0, R};
    vecs[9]  = '{2'b11, 2'b01, 1'b1, D,     2'b01, 2'b01, 1'b0, 1'b1, A0, W0, 2'b00, 1'b0, R};
    vecs[10] = '{2'b11, 2'b01, 1'b1, D,     2'b00, 2'b01, 1'b1, 1'b1, A0, W0, 2'b00, 1'b0, R};
    vecs[11] = '{2'b11, 2'b01, 1'b1, D,     2'b00, 2'b00, 1'b0, 1'b1, A0, W0, 2'b01, 1'b0, 32'h0};
    vecs[12] = '{2'b11, 2'b01, 1'b1, D,     2'b10, 2'b10, 1'b0, 1'b0, A1, W1, 2'b00, 1'b0, 32'h0};
    vecs[13] = '{2'b11, 2'b01, 1'b1, D,     2'b00, 2'b10, 1'b1, 1'b0, A1, W1, 2'b00, 1'b0, 32'h0};
    vecs[14] = '{2'b11, 2'b01, 1'b1, D,     2'b00, 2'b00, 1'b0, 1'b0, A1, W1, 2'b10, 1'b0, D};
    vecs[15] = '{2'b11, 2'b01, 1'b1, D,     2'b01, 2'b01, 1'b0, 1'b1, A0, W0, 2'b00, 1'b0, D};
    vecs[16] = '{2'b11, 2'b01, 1'b1, D,     2'b00, 2'b01, 1'b1, 1'b1, A0, W0, 2'b00, 1'b0, D};
    vecs[17] = '{2'b11, 2'b01, 1'b1, D,     2'b00, 2'b00, 1'b0, 1'b1, A0, W0, 2'b01, 1'b0, 32'h0};
    vecs[18] = '{2'b11, 2'b01, 1'b1, D,     2'b10, 2'b10, 1'b0, 1'b0, A1, W1, 2'b00, 1'b0, 32'h0};
    vecs[19] = '{2'b11, 2'b01, 1'b1, D,     2'b00, 2'b10, 1'b1, 1'b0, A1, W1, 2'b00, 1'b0, 32'h0};
    vecs[20] = '{2'b00, 2'b01, 1'b1, D,     2'b00, 2'b00, 1'b0, 1'b0, A1, W1, 2'b10, 1'b0, D};

    // Reset state; both requesters valid so the reset pointer is visible.
    PRESET    = 1'b1;
    req_valid = 2'b11;
    req_addr  = {A1, A0};
    req_wdata = {W1, W0};
    req_write = 2'b00;
    PREADY    = 1'b0;
    PRDATA    = '0;
    PSLVERR   = 1'b0;
    tick();
    tick();
    check("rst_psel", PSEL, 2'b00);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_pwrite", PWRITE, 1'b0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_slverr", rsp_slverr, 1'b0);
    check("rst_pprot", PPROT, 3'b000);
    check("rst_ready_favours_0", req_ready, 2'b01);
    PRESET = 1'b0;

    // Table: single write, stalled read, then four alternating transfers.
    for (int i = 0; i < 21; i++) begin
      req_valid = vecs[i].valid;
      req_write = vecs[i].wr;
      PREADY    = vecs[i].pready;
      PRDATA    = vecs[i].prdata;
      #1 check($sformatf("v%0d_ready", i), req_ready, vecs[i].e_ready);
      tick();
      check($sformatf("v%0d_psel", i), PSEL, vecs[i].e_psel);
      check($sformatf("v%0d_penable", i), PENABLE, vecs[i].e_pen);
      check($sformatf("v%0d_pwrite", i), PWRITE, vecs[i].e_pwrite);
      check($sformatf("v%0d_paddr", i), PADDR, vecs[i].e_paddr);
      check($sformatf("v%0d_pwdata", i), PWDATA, vecs[i].e_pwdata);
      check($sformatf("v%0d_rsp_valid", i), rsp_valid, vecs[i].e_rsp);
      check($sformatf("v%0d_rsp_slverr", i), rsp_slverr, vecs[i].e_err);
      check($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].e_rdata);
    end

    // Timeout: slave never ready; ACCESS lasts 16 cycles, then abort.
    req_addr[31:0] = A0;
    req_write      = 2'b00;
    req_valid      = 2'b01;
    PREADY         = 1'b0;
    #1 check("to_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("to_setup_psel", PSEL, 2'b01);
    tick();
    check("to_access_pen", PENABLE, 1'b1);
    repeat (15) tick();
    check("to_still_psel", PSEL, 2'b01);
    check("to_still_pen", PENABLE, 1'b1);
    check("to_no_rsp_yet", rsp_valid, 2'b00);
    tick();
    check("to_psel_drop", PSEL, 2'b00);
    check("to_pen_drop", PENABLE, 1'b0);
    check("to_rsp_valid", rsp_valid, 2'b01);
    check("to_rsp_err", rsp_slverr, 1'b1);
    check("to_rsp_rdata", rsp_rdata, 32'h0);

    // Clean read, slave error, clean write (slave 0 via address 0xFFC).
    xfer(1, A1, 1'b0, 32'h0000_00C3, 1'b0, 2'b10, 32'h0000_00C3, 1'b0, "rd_ok");
    xfer(0, 32'h0000_1010, 1'b0, 32'h0, 1'b1, 2'b10, 32'h0, 1'b1, "rd_slverr");
    xfer(1, 32'h0000_0FFC, 1'b1, 32'h0000_0077, 1'b0, 2'b01, 32'h0, 1'b0, "wr_ok");

    // Decode error: address above the select bit never reaches the bus.
    req_addr[31:0] = 32'h0001_0000;
    req_write      = 2'b00;
    req_valid      = 2'b01;
    PREADY         = 1'b1;
    PRDATA         = 32'h0000_0099;
    #1 check("derr_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("derr_psel", PSEL, 2'b00);
    check("derr_pen", PENABLE, 1'b0);
    check("derr_no_rsp", rsp_valid, 2'b00);
    check("derr_paddr", PADDR, 32'h0001_0000);
    tick();
    check("derr_rsp_valid", rsp_valid, 2'b01);
    check("derr_rsp_err", rsp_slverr, 1'b1);
    check("derr_rsp_rdata", rsp_rdata, 32'h0);
    check("derr_psel_after", PSEL, 2'b00);
    tick();
    check("derr_rsp_pulse", rsp_valid, 2'b00);
    check("derr_err_hold", rsp_slverr, 1'b1);

    // Reset during a stalled ACCESS aborts silently.
    req_addr[31:0] = 32'h0000_0008;
    req_valid      = 2'b01;
    PREADY         = 1'b0;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    check("rst2_stalled_pen", PENABLE, 1'b1);
    PRESET    = 1'b1;
    req_valid = 2'b11;
    tick();
    check("rst2_psel", PSEL, 2'b00);
    check("rst2_penable", PENABLE, 1'b0);
    check("rst2_paddr", PADDR, 32'h0);
    check("rst2_pwdata", PWDATA, 32'h0);
    check("rst2_rsp_valid", rsp_valid, 2'b00);
    check("rst2_rsp_slverr", rsp_slverr, 1'b0);
    check("rst2_ready_favours_0", req_ready, 2'b01);
    PRESET    = 1'b0;
    req_valid = 2'b00;
    tick();
    check("rst2_no_rsp_1", rsp_valid, 2'b00);
    check("rst2_idle_psel", PSEL, 2'b00);
    tick();
    check("rst2_no_rsp_2", rsp_valid, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
APB master that shares one APB bus between two requesters and drives the two-slave APB fabric (PSEL[1:0], muxed PREADY/PRDATA/PSLVERR).
- Each requester issues single read/write commands over a valid/ready interface.
- The block arbitrates round-robin, decodes the target slave from the address and sequences the APB SETUP/ACCESS phases.
- It returns read data and error status to the requester and guards against hung slaves with a timeout.

Parameters:
ADDR_WIDTH, 32, width of PADDR and request addresses
DATA_WIDTH, 32, width of PWDATA/PRDATA and request/response data
SEL_BIT, 12, address bit selecting slave 0 (bit=0) or slave 1 (bit=1)
TIMEOUT_CYCLES, 16, max ACCESS-phase wait cycles before abort; 0 disables timeout

Ports:
PCLK  in  1  bus clock; all logic on rising edge
PRESET  in  1  synchronous, active-high reset
req_valid  in  2  per-requester command valid
req_ready  out  2  per-requester command accept; handshake = valid & ready
req_addr  in  2*ADDR_WIDTH  packed; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_write  in  2  1 = write, 0 = read
req_wdata  in  2*DATA_WIDTH  packed write data, same layout as req_addr
rsp_valid  out  2  one-cycle response pulse to the granted requester
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid; 0 for writes and errors
rsp_slverr  out  1  error flag, valid with rsp_valid
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  2  one-hot slave select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PPROT  out  3  tied 3'b000
PREADY  in  1  muxed slave ready
PRDATA  in  DATA_WIDTH  muxed slave read data
PSLVERR  in  1  muxed slave error

Behaviour:
- Reset (PRESET=1 at edge): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_slverr all 0; round-robin pointer favours requester 0; timeout counter 0.
- A reset asserted mid-transfer aborts it. No response is issued and PSEL/PENABLE are 0 after that edge.
- FSM states: IDLE, SETUP, ACCESS, DERR.
- IDLE, arbitration:
  - req_ready is combinational and asserted only in IDLE, only for the winner.
  - Winner: if one requester is valid, it wins. If both are valid, the one not granted last wins.
  - Pointer updates on each grant.
- IDLE, on grant:
  - Latch addr, write and wdata into PADDR, PWRITE and PWDATA (registered). Record the grant index.
  - Address decode: if any address bit above SEL_BIT is 1, go to DERR. Otherwise set PSEL[addr[SEL_BIT]]=1, PENABLE=0, and go to SETUP.
- DERR (one cycle, no APB activity, PSEL stays 0):
  - Next edge: rsp_valid[g]=1, rsp_slverr=1, rsp_rdata=0.
  - Return to IDLE.
- SETUP (exactly one cycle): next edge sets PENABLE=1 and goes to ACCESS. PADDR, PWRITE, PWDATA and PSEL are held.
- ACCESS: all APB outputs stay stable until completion.
  - PREADY=1: next edge clears PSEL and PENABLE, clears the counter and returns to IDLE. Response fields on that edge:
    - rsp_valid[g]=1
    - rsp_slverr=PSLVERR
    - rsp_rdata = PRDATA for reads, 0 for writes
  - PREADY=0: the counter increments.
  - Timeout: when TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with PREADY still 0, the transfer is aborted. The next edge clears PSEL and PENABLE and drives rsp_valid[g]=1, rsp_slverr=1, rsp_rdata=0.
- rsp_valid is a single-cycle pulse with no backpressure; requesters must accept it. rsp_rdata and rsp_slverr hold their value until the next response.
- Throughput: minimum 3 cycles per transfer (IDLE grant, SETUP, ACCESS with PREADY=1). No new grant is made until the FSM is back in IDLE.
- Request inputs are ignored outside the IDLE handshake, so changing them mid-transfer has no effect.
- Exactly one PSEL bit, or none, is asserted at any time. PENABLE=1 implies a PSEL bit is set.

Test Plan:
- Reset, then requester 0 writes addr 0x0000_0004, data 0xDEADBEEF; slave PREADY=1 immediately -> PSEL=2'b01 for 2 cycles, PENABLE high in cycle 2 only, PWRITE=1, rsp_valid=2'b01 one cycle after, rsp_slverr=0, rsp_rdata=0.
- Requester 1 reads 0x0000_1008 (SEL_BIT=12); slave holds PREADY=0 for 3 cycles then returns PRDATA=0x1234_5678 -> PSEL=2'b10, ACCESS lasts 4 cycles, rsp_valid=2'b10, rsp_rdata=0x1234_5678.
- Both requesters valid every cycle for 4 transfers -> grants alternate 0,1,0,1; each req_ready pulse is 1 cycle; PSEL never 2'b11.
- Read to 0x0001_0000 -> no PSEL assertion, rsp_valid one cycle after DERR with rsp_slverr=1, rsp_rdata=0. Separately, slave returns PSLVERR=1 with PREADY=1 -> rsp_slverr=1.
- Slave never asserts PREADY, TIMEOUT_CYCLES=16 -> PSEL/PENABLE drop after 16 wait cycles, rsp_slverr=1. Then PRESET asserted during a stalled ACCESS -> all outputs 0 next cycle, no rsp_valid.
